// File: rtl/disp_pkg.sv
// Shared types and constants for the scanned two-digit seven-segment display.
// Segment codes are {g,f,e,d,c,b,a}, active-low.
package disp_pkg;

    typedef enum logic [1:0] {DIG0, DEAD0, DIG1, DEAD1} scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/seg_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg_decode
    import disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (digit)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/sum_display_scan.sv
// Scanned two-digit display for the adder result: latches {carry, sum} on load and
// multiplexes one segment bus across two anodes with a dead gap between digits.
module sum_display_scan
    import disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DEAD_CYC    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sum,
    input  logic       carry,
    input  logic       load,
    input  logic       blank_lead,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int unsigned CNT_MAX = (REFRESH_DIV > DEAD_CYC) ? REFRESH_DIV : DEAD_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] DIG_RELOAD  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_RELOAD = CNT_W'(DEAD_CYC - 1);

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       val_q;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;
    logic [3:0]       digit;
    logic [6:0]       dig_seg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DIG0;
            cnt_q   <= DIG_RELOAD;
            val_q   <= 5'd0;
            seg_q   <= SEG_BLANK;
            an_q    <= 2'b11;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) val_q <= {carry, sum};
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
            unique case (state_q)
                DIG0:  begin state_d = DEAD0; cnt_d = DEAD_RELOAD; end
                DEAD0: begin state_d = DIG1;  cnt_d = DIG_RELOAD;  end
                DIG1:  begin state_d = DEAD1; cnt_d = DEAD_RELOAD; end
                DEAD1: begin state_d = DIG0;  cnt_d = DIG_RELOAD;  end
            endcase
        end
    end

    // Outputs are registered from the current state, so an and seg switch together.
    assign digit = (state_q == DIG1) ? {3'b000, val_q[4]} : val_q[3:0];

    seg_decode u_seg_decode (
        .digit (digit),
        .seg   (dig_seg)
    );

    always_comb begin
        an_d  = 2'b11;
        seg_d = SEG_BLANK;
        unique case (state_q)
            DIG0: begin
                an_d  = 2'b10;
                seg_d = dig_seg;
            end
            DIG1: begin
                an_d = 2'b01;
                if (!(blank_lead && !val_q[4])) seg_d = dig_seg;
            end
            DEAD0, DEAD1: ;
        endcase
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_sum_display_scan.sv
// Self-checking bench for sum_display_scan with a cycle-position model and scoreboard.
module tb_sum_display_scan;

    localparam int unsigned RDIV   = 4;
    localparam int unsigned DCYC   = 2;
    localparam int unsigned PERIOD = 2 * (RDIV + DCYC);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sum = 4'h0;
    logic       carry = 1'b0;
    logic       load = 1'b0;
    logic       blank_lead = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;

    sum_display_scan #(
        .REFRESH_DIV (RDIV),
        .DEAD_CYC    (DCYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sum        (sum),
        .carry      (carry),
        .load       (load),
        .blank_lead (blank_lead),
        .seg        (seg),
        .an         (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] an;
        logic [6:0] seg;
    } exp_t;

    typedef struct {
        logic [3:0] sum;
        logic       carry;
        logic       bl;
        logic [6:0] s0;
        logic [6:0] s1;
    } vec_t;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [4:0] m_val = 5'd0;
    int         m_pos = 0;
    logic [6:0] last_seg0 = 7'h7F;
    logic [6:0] last_seg1 = 7'h7F;
    vec_t       vecs [6];

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got an=%b seg=%h, want an=%b seg=%h", name, $time,
                     act[8:7], act[6:0], req[8:7], req[6:0]);
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        e.an  = 2'b11;
        e.seg = 7'h7F;
        if (m_pos < int'(RDIV)) begin
            e.an  = 2'b10;
            e.seg = hex_tab[m_val[3:0]];
        end else if (m_pos >= int'(RDIV + DCYC) && m_pos < int'(2 * RDIV + DCYC)) begin
            e.an  = 2'b01;
            e.seg = (blank_lead && !m_val[4]) ? 7'h7F : hex_tab[{3'b000, m_val[4]}];
        end
        return e;
    endfunction

    // One clock: push the prediction for the coming edge, then compare after it.
    task automatic step();
        exp_t e;
        e = predict();
        sb.push_back(e);
        if (load) m_val = {carry, sum};
        m_pos = (m_pos + 1) % int'(PERIOD);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", {an, seg}, 9'h1FF);
        end else begin
            e = sb.pop_front();
            check("scan", {an, seg}, {e.an, e.seg});
        end
        if (an == 2'b11) check("dead_blank", {an, seg}, {2'b11, 7'h7F});
        if (an == 2'b10) last_seg0 = seg;
        if (an == 2'b01) last_seg1 = seg;
    endtask

    task automatic run_to(input int pos);
        while (m_pos != pos) step();
    endtask

    task automatic do_load(input logic [3:0] s, input logic c);
        sum   = s;
        carry = c;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    initial begin
        vecs[0] = '{4'hA, 1'b1, 1'b0, 7'h08, 7'h79};
        vecs[1] = '{4'h5, 1'b0, 1'b1, 7'h12, 7'h7F};
        vecs[2] = '{4'h5, 1'b0, 1'b0, 7'h12, 7'h40};
        vecs[3] = '{4'hF, 1'b1, 1'b1, 7'h0E, 7'h79};
        vecs[4] = '{4'h8, 1'b0, 1'b0, 7'h00, 7'h40};
        vecs[5] = '{4'h0, 1'b1, 1'b1, 7'h40, 7'h79};

        // Reset held low
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", {an, seg}, {2'b11, 7'h7F});
        rst_n = 1'b1;
        m_pos = 0;
        m_val = 5'd0;
        step();
        check("first_edge", {an, seg}, {2'b10, 7'h40});
        repeat (PERIOD - 1) step();

        // Table: load, let it settle into a full scan, check each digit's code
        foreach (vecs[i]) begin
            blank_lead = vecs[i].bl;
            do_load(vecs[i].sum, vecs[i].carry);
            run_to(0);
            repeat (PERIOD) step();
            check("vec_dig0", {2'b10, last_seg0}, {2'b10, vecs[i].s0});
            check("vec_dig1", {2'b01, last_seg1}, {2'b01, vecs[i].s1});
        end

        // Load on the second DIG0 cycle; new code from the next edge, anode timing unchanged
        blank_lead = 1'b0;
        run_to(1);
        do_load(4'h8, 1'b0);
        check("midslot_next", {an, seg}, {2'b10, 7'h40});
        step();
        check("midslot_new", {an, seg}, {2'b10, 7'h00});
        run_to(0);

        // Load held high: display tracks the inputs every cycle
        load = 1'b1;
        for (int k = 0; k < int'(PERIOD); k++) begin
            sum   = 4'(k);
            carry = k[1];
            step();
        end
        load = 1'b0;

        // Async reset in the middle of DIG1
        do_load(4'hA, 1'b1);
        run_to(7);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_now", {an, seg}, {2'b11, 7'h7F});
        @(posedge clk);
        #1;
        check("async_rst_hold", {an, seg}, {2'b11, 7'h7F});
        rst_n = 1'b1;
        m_pos = 0;
        m_val = 5'd0;
        step();
        check("restart_dig0", {an, seg}, {2'b10, 7'h40});
        repeat (PERIOD - 1) step();

        // Decoder sweep with assorted carry / blanking combinations
        for (int i = 0; i < 16; i++) begin
            blank_lead = (i % 3) == 0;
            run_to(0);
            do_load(4'(i), i[0]);
            repeat (PERIOD - 1) step();
            check("sweep_dig0", {2'b10, last_seg0}, {2'b10, hex_tab[i]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sum_display_scan.md
# sum_display_scan

Time-multiplexed two-digit seven-segment driver that sits directly downstream of the 4-bit add/subtract stage. It latches the 4-bit sum and carry on a load strobe and drives one shared active-low segment bus. Two active-low digit anodes are scanned with a dead-time gap between digits to prevent ghosting. This replaces the two static per-digit decoders with a board-friendly scanned display.

## Interface

- `REFRESH_DIV`, 50000, cycles each digit is lit per scan slot; must be ≥ 2.
- `DEAD_CYC`, 16, cycles with both anodes off between digits; must be ≥ 1.

- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `sum`  in  4  sum/difference nibble from the adder stage.
- `carry`  in  1  carry/borrow out from the adder stage.
- `load`  in  1  one-cycle strobe; captures `sum`/`carry`.
- `blank_lead`  in  1  1 = blank the upper digit when the latched carry is 0.
- `seg`  out  7  `{g,f,e,d,c,b,a}`, active-low, shared by both digits.
- `an`  out  2  digit enables, active-low; `an[0]` = low digit (sum), `an[1]` = upper digit (carry).

## Operation

- **Value register:** `val[4:0] = {carry, sum}`.
  - Loaded on any rising edge with `load = 1`.
  - Held otherwise.
  - Reset value 0.
- **Digit values:**
  - Digit 0 shows hex `val[3:0]`.
  - Digit 1 shows `{3'b000, val[4]}`, i.e. 0 or 1.
  - Digit 1 segments are forced to 7'h7F (all off) when `blank_lead = 1` and `val[4] = 0`; its anode is still asserted.
- **Segment codes:** standard hex, active-low.
  - 0 = 7'h40, 1 = 7'h79, 5 = 7'h12, 8 = 7'h00, A = 7'h08, F = 7'h0E.
  - All 16 codes are defined; there is no don't-care.
- **Scan FSM:** states DIG0, DEAD0, DIG1, DEAD1, visited cyclically, with one down-counter `cnt`.
  - DIG0: `an = 2'b10`, `seg = code(digit0)`. Lasts `REFRESH_DIV` cycles, then DEAD0.
  - DEAD0: `an = 2'b11`, `seg = 7'h7F`. Lasts `DEAD_CYC` cycles, then DIG1.
  - DIG1: `an = 2'b01`, `seg = code(digit1)` or blank. Lasts `REFRESH_DIV` cycles, then DEAD1.
  - DEAD1: same outputs as DEAD0. Lasts `DEAD_CYC` cycles, then DIG0.
- **Counter:** width `$clog2(max(REFRESH_DIV, DEAD_CYC))`.
  - Reloaded on each state entry.
  - State advances on the edge where `cnt == 0`.
- **Reset (`rst_n` low, any time, including mid-scan):**
  - `an = 2'b11`, `seg = 7'h7F`, `val = 0`.
  - FSM is forced to DIG0 with `cnt = REFRESH_DIV-1`.
- **Load while lit:** a digit reflects a new value without waiting for the next slot; no restart of the scan.
- **`load` held high:** re-captures on every cycle, so the display tracks the inputs.

## Timing

- `an` and `seg` are registered; there is no combinational path from inputs to outputs.
- **First edge after reset release:** `an = 2'b10`, `seg = 7'h40`.
- **Scan period:** `2*(REFRESH_DIV + DEAD_CYC)` cycles.
  - `an[0]` low for exactly `REFRESH_DIV` consecutive cycles.
  - `an[1]` low for exactly `REFRESH_DIV` consecutive cycles.
  - Both anodes high for exactly `DEAD_CYC` cycles between them.
- **Load latency:** `load` sampled at edge t updates `val` at t; `seg` shows the new value at edge t+1 if the relevant digit is lit.
- **Anode/segment alignment:** `an` and `seg` change on the same edge. `seg` is never non-blank while both anodes are off, and never shows the other digit's code while an anode is low.

## Structure

- **Shared package `disp_pkg`:**
  - Scan state enum `{DIG0, DEAD0, DIG1, DEAD1}`.
  - Constant `SEG_BLANK = 7'h7F`.
  - Hex-to-segment code constants.
- **Sub-module `seg_decode`:** combinational 4-bit-to-active-low-7-segment decoder, instantiated once on the muxed digit value.
- **Top level:** holds the value register, counter, FSM and output registers.

## Test plan

Bench parameters: `REFRESH_DIV = 4`, `DEAD_CYC = 2`.

- **Reset:** hold `rst_n` low -> `an = 2'b11`, `seg = 7'h7F`. Release -> next edge `an = 2'b10`, `seg = 7'h40`; full scan period 12 cycles with pattern 10×4, 11×2, 01×4, 11×2.
- **Load with carry:** load `sum = 4'hA`, `carry = 1`, `blank_lead = 0` -> DIG0 `seg = 7'h08`, DIG1 `seg = 7'h79`, dead slots 7'h7F.
- **Leading-digit blanking:** load `sum = 5`, `carry = 0`, `blank_lead = 1` -> DIG0 `seg = 7'h12`, DIG1 `an = 2'b01` with `seg = 7'h7F`. Drop `blank_lead` -> DIG1 shows 7'h40.
- **Load mid-slot:** strobe `load` with `sum = 8` on the 2nd DIG0 cycle -> `seg = 7'h00` from the next edge. `an` timing is unchanged: still 4 cycles low.
- **Async reset mid-DIG1:** assert `rst_n` low between edges -> outputs go blank and anodes off immediately, `val` clears, and the scan restarts at DIG0 after release.
- **Decoder sweep:** load 0..F on successive scans -> every DIG0 code matches the `disp_pkg` table, with no `an`/`seg` overlap at any transition.
